// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control block: FSM state encoding and
// the default number of cycles needed to retire the back-end stages.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } pipe_state_e;

  localparam int unsigned DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; it holds at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int NB = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc_en,
  output logic [NB-1:0] count
);

  logic [NB-1:0] count_q;
  logic [NB-1:0] count_d;

  function automatic logic [NB-1:0] sat_inc(input logic [NB-1:0] v);
    return (&v) ? v : v + NB'(1);
  endfunction

  always_comb begin
    count_d = count_q;
    if (inc_en) count_d = sat_inc(count_q);
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control FSM: turns hazard, branch and HALT requests into latch
// write enables, drains the back end after a HALT and counts cycles/stalls.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int          NB_CNT       = 32,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_hazard,
  input  logic              i_branch_taken,
  input  logic              i_halt_id,
  output logic              o_pc_we,
  output logic              o_if_id_we,
  output logic              o_if_id_flush,
  output logic              o_id_ex_bubble,
  output logic              o_back_we,
  output logic              o_halted,
  output logic [NB_CNT-1:0] o_stall_count,
  output logic [NB_CNT-1:0] o_cycle_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  pipe_state_e   state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          cyc_inc;
  logic          stall_inc;

  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    cyc_inc        = 1'b0;
    stall_inc      = 1'b0;
    o_pc_we        = 1'b0;
    o_if_id_we     = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_back_we      = 1'b0;
    if (!i_reset && i_valid) begin
      unique case (state_q)
        ST_RUN: begin
          cyc_inc   = 1'b1;
          o_back_we = 1'b1;
          // Hazard outranks HALT, which outranks a taken branch.
          if (i_hazard) begin
            o_id_ex_bubble = 1'b1;
            stall_inc      = 1'b1;
          end else if (i_halt_id) begin
            o_id_ex_bubble = 1'b1;
            drain_d        = DW'(DRAIN_CYCLES - 1);
            state_d        = ST_DRAIN;
          end else if (i_branch_taken) begin
            o_pc_we       = 1'b1;
            o_if_id_flush = 1'b1;
          end else begin
            o_pc_we    = 1'b1;
            o_if_id_we = 1'b1;
          end
        end
        ST_DRAIN: begin
          cyc_inc        = 1'b1;
          o_back_we      = 1'b1;
          o_id_ex_bubble = 1'b1;
          if (drain_q == '0) state_d = ST_HALTED;
          else               drain_d = drain_q - DW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  assign o_halted = (state_q == ST_HALTED);

  sat_counter #(.NB(NB_CNT)) u_cycle_cnt (
    .clock  (i_clock),
    .reset  (i_reset),
    .inc_en (cyc_inc),
    .count  (o_cycle_count)
  );

  sat_counter #(.NB(NB_CNT)) u_stall_cnt (
    .clock  (i_clock),
    .reset  (i_reset),
    .inc_en (stall_inc),
    .count  (o_stall_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a 32-bit and a 4-bit-counter instance
// share stimulus; expected responses are queued and checked by a monitor.
module tb_pipeline_ctrl;

  localparam int NB  = 32;
  localparam int NB4 = 4;
  localparam int DC  = 3;

  logic clk = 1'b0;
  logic rst, valid, hazard, branch, halt;

  logic a_pc_we, a_if_id_we, a_flush, a_bubble, a_back_we, a_halted;
  logic [NB-1:0] a_stall, a_cyc;
  logic b_pc_we, b_if_id_we, b_flush, b_bubble, b_back_we, b_halted;
  logic [NB4-1:0] b_stall, b_cyc;

  always #5 clk = ~clk;

  pipeline_ctrl #(.NB_CNT(NB), .DRAIN_CYCLES(DC)) dut (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_hazard(hazard),
    .i_branch_taken(branch), .i_halt_id(halt),
    .o_pc_we(a_pc_we), .o_if_id_we(a_if_id_we), .o_if_id_flush(a_flush),
    .o_id_ex_bubble(a_bubble), .o_back_we(a_back_we), .o_halted(a_halted),
    .o_stall_count(a_stall), .o_cycle_count(a_cyc)
  );

  pipeline_ctrl #(.NB_CNT(NB4), .DRAIN_CYCLES(DC)) dut4 (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_hazard(hazard),
    .i_branch_taken(branch), .i_halt_id(halt),
    .o_pc_we(b_pc_we), .o_if_id_we(b_if_id_we), .o_if_id_flush(b_flush),
    .o_id_ex_bubble(b_bubble), .o_back_we(b_back_we), .o_halted(b_halted),
    .o_stall_count(b_stall), .o_cycle_count(b_cyc)
  );

  typedef struct {
    logic        pc_we, if_id_we, flush, bubble, back_we, halted;
    logic [31:0] stall, cyc;
    logic [31:0] stall4, cyc4;
  } exp_t;

  exp_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: halted flag, remaining drain cycles, unbounded counts.
  bit     m_halted = 1'b0;
  int     m_drain  = 0;
  longint m_cyc = 0, m_stall = 0, m_cyc4 = 0, m_stall4 = 0;

  function automatic longint sat(input longint v, input longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit hz, input bit br, input bit ht);
    exp_t e;
    @(posedge clk); #1;
    rst = r; valid = v; hazard = hz; branch = br; halt = ht;
    e.pc_we = 0; e.if_id_we = 0; e.flush = 0; e.bubble = 0; e.back_we = 0;
    e.halted = m_halted;
    e.stall  = 32'(m_stall);
    e.cyc    = 32'(m_cyc);
    e.stall4 = 32'(m_stall4);
    e.cyc4   = 32'(m_cyc4);
    if (!r && v && !m_halted) begin
      e.back_we = 1;
      if (m_drain > 0 || hz || ht) e.bubble = 1;
      else begin
        e.pc_we = 1;
        if (br) e.flush = 1;
        else    e.if_id_we = 1;
      end
    end
    sb_q.push_back(e);
    if (r) begin
      m_halted = 0; m_drain = 0; m_cyc = 0; m_stall = 0; m_cyc4 = 0; m_stall4 = 0;
    end else if (v && !m_halted) begin
      m_cyc  = sat(m_cyc, 64'hFFFF_FFFF);
      m_cyc4 = sat(m_cyc4, 15);
      if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) m_halted = 1;
      end else if (hz) begin
        m_stall  = sat(m_stall, 64'hFFFF_FFFF);
        m_stall4 = sat(m_stall4, 15);
      end else if (ht) begin
        m_drain = DC;
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cmp("pc_we",     32'(a_pc_we),    32'(e.pc_we));
      cmp("if_id_we",  32'(a_if_id_we), 32'(e.if_id_we));
      cmp("flush",     32'(a_flush),    32'(e.flush));
      cmp("bubble",    32'(a_bubble),   32'(e.bubble));
      cmp("back_we",   32'(a_back_we),  32'(e.back_we));
      cmp("halted",    32'(a_halted),   32'(e.halted));
      cmp("stall_cnt", a_stall,         e.stall);
      cmp("cycle_cnt", a_cyc,           e.cyc);
      cmp("pc_we4",    32'(b_pc_we),    32'(e.pc_we));
      cmp("flush4",    32'(b_flush),    32'(e.flush));
      cmp("halted4",   32'(b_halted),   32'(e.halted));
      cmp("stall_cnt4", 32'(b_stall),   e.stall4);
      cmp("cycle_cnt4", 32'(b_cyc),     e.cyc4);
    end
  end

  initial begin
    int n;
    rst = 1; valid = 0; hazard = 0; branch = 0; halt = 0;
    repeat (2) @(posedge clk);
    // Reset overrides valid and every request.
    repeat (2) step(1, 1, 1, 1, 1);
    repeat (10) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    repeat (2) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1);
    step(0, 1, 1, 1, 1);
    repeat (2) step(0, 0, 1, 1, 1);
    repeat (4) step(0, 1, 1, 0, 0);
    repeat (3) step(0, 1, 1, 1, 1);
    step(1, 1, 0, 0, 0);
    repeat (20) step(0, 1, 1, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) < 3);
    end
    n = 0;
    while (sb_q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
